// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshot the array's result matrix on done rise and stream it row-major over valid/ready
module systolic_result_drain #(
  parameter int BITWIDTH = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 1,
  parameter int X_ROW = 3,
  parameter int Y_COL = 3,
  parameter int OUT_BITWIDTH = 16,
  localparam int RW = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1),
  localparam int RBW = X_ROW > 1 ? $clog2(X_ROW) : 1,
  localparam int CBW = Y_COL > 1 ? $clog2(Y_COL) : 1
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           array_done,
  input  logic [RW*X_ROW*Y_COL-1:0]      Z,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic signed [OUT_BITWIDTH-1:0] m_data,
  output logic [RBW-1:0]                 m_row,
  output logic [CBW-1:0]                 m_col,
  output logic                           m_last,
  output logic                           busy,
  output logic                           overrun,
  output logic                           sat_flag,
  input  logic                           clear_flags
);
  localparam int N = X_ROW * Y_COL;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic done_d;
  logic signed [RW-1:0] snap [N];
  logic [IW-1:0] idx;
  logic [RBW-1:0] row;
  logic [CBW-1:0] col;
  logic signed [RW-1:0] cur;
  logic signed [OUT_BITWIDTH-1:0] data_c;
  logic clip, done_rise, hs, last_hs;
  assign done_rise = array_done & ~done_d;
  assign busy = state == SEND;
  assign m_valid = busy;
  assign m_last = busy && idx == IW'(N - 1);
  assign hs = busy & m_ready;
  assign last_hs = hs & m_last;
  assign cur = snap[idx];
  assign m_data = data_c;
  assign m_row = row;
  assign m_col = col;
  if (OUT_BITWIDTH >= RW) begin : g_ext
    assign data_c = OUT_BITWIDTH'(cur);
    assign clip = 1'b0;
  end else begin : g_sat
    localparam logic signed [RW-1:0] HI = RW'((64'sd1 <<< (OUT_BITWIDTH - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] LO = ~HI;
    assign clip = (cur > HI) || (cur < LO);
    assign data_c = cur > HI ? HI[OUT_BITWIDTH-1:0] : cur < LO ? LO[OUT_BITWIDTH-1:0] : cur[OUT_BITWIDTH-1:0];
  end
  // capture on done rise (also back-to-back on the last handshake), walk the pointer on each handshake, keep sticky flags
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      done_d <= 1'b1;
      idx <= '0;
      row <= '0;
      col <= '0;
      overrun <= 1'b0;
      sat_flag <= 1'b0;
      for (int i = 0; i < N; i++) snap[i] <= '0;
    end else begin
      done_d <= array_done;
      if (done_rise && (!busy || last_hs)) begin
        state <= SEND;
        idx <= '0;
        row <= '0;
        col <= '0;
        for (int i = 0; i < N; i++) snap[i] <= Z[i*RW +: RW];
      end else if (hs) begin
        if (m_last) state <= IDLE;
        else begin
          idx <= idx + 1'b1;
          col <= col == CBW'(Y_COL - 1) ? '0 : col + 1'b1;
          row <= col == CBW'(Y_COL - 1) ? row + 1'b1 : row;
        end
      end
      overrun <= (done_rise & busy & ~last_hs) ? 1'b1 : clear_flags ? 1'b0 : overrun;
      sat_flag <= (hs & clip) ? 1'b1 : clear_flags ? 1'b0 : sat_flag;
    end
  end
endmodule
